// File: rtl/vga_scanout_if.sv
// Draw-request channel from the CPU core into the scanout block.
// Latency: n/a (signal bundle only).
// Backpressure: O_WR_READY low while the single-entry hold register is occupied.
interface vga_scanout_if;
    logic       I_WR_VALID;
    logic [8:0] I_WR_X;
    logic [7:0] I_WR_Y;
    logic [2:0] I_WR_COLOR;
    logic       O_WR_READY;
    logic       O_WR_DROP;

    modport master (
        output I_WR_VALID, I_WR_X, I_WR_Y, I_WR_COLOR,
        input  O_WR_READY, O_WR_DROP
    );

    modport slave (
        input  I_WR_VALID, I_WR_X, I_WR_Y, I_WR_COLOR,
        output O_WR_READY, O_WR_DROP
    );
endinterface

// File: rtl/vga_scanout.sv
// 320x240x3 framebuffer with draw port, scanned out as pixel-doubled 640x480 VGA.
// Latency: video/sync pins show counter position (h,v) 3 CLK after the counters reach it.
// Backpressure: one held draw at a time; ready drops on accept, returns the cycle after commit.
module vga_scanout #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic          CLK,
    input  logic          I_RESET_N,
    vga_scanout_if.slave  wr,
    output logic          O_VBLANK,
    output logic          O_HSYNC,
    output logic          O_VSYNC,
    output logic [3:0]    O_VIDEO_R,
    output logic [3:0]    O_VIDEO_G,
    output logic [3:0]    O_VIDEO_B
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W    = $clog2(CLK_DIV);
    localparam int FB_DEPTH = 320 * 240;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] H_SYNC_B = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_E = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] V_SYNC_B = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_E = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [9:0]       h_cnt, v_cnt, h_nxt, v_nxt;
    logic             tick;
    logic             active, hs_n, vs_n, rd_slot;
    logic [16:0]      rd_addr, wr_addr_in;
    logic             in_range, accept, commit;

    logic             hold_vld;
    logic [16:0]      hold_addr;
    logic [2:0]       hold_col;

    logic [2:0]       fb_mem [0:FB_DEPTH-1];
    logic [2:0]       rd_dat;

    logic             d1_act, d1_hs, d1_vs;
    logic [2:0]       d2_col;
    logic             d2_hs, d2_vs;

    // Next raster position: advance one pixel per tick, wrap line then frame.
    always_comb begin
        tick  = (div_cnt == DIV_LAST);
        h_nxt = h_cnt;
        v_nxt = v_cnt;
        if (tick) begin
            if (h_cnt == H_LAST) begin
                h_nxt = '0;
                v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
            end else begin
                h_nxt = h_cnt + 10'd1;
            end
        end
    end

    // Timing decode, framebuffer addressing and write-port arbitration for the current position.
    always_comb begin
        active     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_n       = !((h_cnt >= H_SYNC_B) && (h_cnt < H_SYNC_E));
        vs_n       = !((v_cnt >= V_SYNC_B) && (v_cnt < V_SYNC_E));
        // One fetch per doubled pixel pair, in the first cycle of the even pixel.
        rd_slot    = (div_cnt == '0) && active && !h_cnt[0];
        // y*320 + x as shifts: (y<<8) + (y<<6) + x.
        rd_addr    = 17'({v_cnt[8:1], 8'd0}) + 17'({v_cnt[8:1], 6'd0}) + 17'(h_cnt[9:1]);
        wr_addr_in = 17'({wr.I_WR_Y, 8'd0}) + 17'({wr.I_WR_Y, 6'd0}) + 17'(wr.I_WR_X);
        in_range   = (wr.I_WR_X < 9'd320) && (wr.I_WR_Y < 8'd240);
        accept     = wr.I_WR_VALID && wr.O_WR_READY;
        // Scanout owns the single RAM port in a read slot; the held draw waits.
        commit     = hold_vld && !rd_slot;
    end

    // Pixel divider and raster counters; vblank tracks the counter with no extra delay.
    always_ff @(posedge CLK) begin
        if (!I_RESET_N) begin
            div_cnt  <= '0;
            h_cnt    <= '0;
            v_cnt    <= '0;
            O_VBLANK <= 1'b0;
        end else begin
            div_cnt  <= tick ? '0 : div_cnt + 1'b1;
            h_cnt    <= h_nxt;
            v_cnt    <= v_nxt;
            O_VBLANK <= (v_nxt >= V_ACT);
        end
    end

    // Draw intake: range-check on accept, hold in-range requests until the RAM port is free.
    always_ff @(posedge CLK) begin
        if (!I_RESET_N) begin
            hold_vld      <= 1'b0;
            wr.O_WR_READY <= 1'b0;
            wr.O_WR_DROP  <= 1'b0;
        end else begin
            wr.O_WR_DROP <= accept && !in_range;
            if (accept && in_range) begin
                hold_vld      <= 1'b1;
                hold_addr     <= wr_addr_in;
                hold_col      <= wr.I_WR_COLOR;
                wr.O_WR_READY <= 1'b0;
            end else if (commit) begin
                hold_vld      <= 1'b0;
                wr.O_WR_READY <= 1'b1;
            end else begin
                wr.O_WR_READY <= !hold_vld;
            end
        end
    end

    // Single-port framebuffer; contents survive reset, but a draw still held at reset is dropped.
    always_ff @(posedge CLK) begin
        if (rd_slot) begin
            rd_dat <= fb_mem[rd_addr];
        end else if (commit && I_RESET_N) begin
            fb_mem[hold_addr] <= hold_col;
        end
    end

    // Three-stage delay line keeping sync and colour aligned; rd_dat carries the pair for the odd pixel.
    always_ff @(posedge CLK) begin
        if (!I_RESET_N) begin
            d1_act    <= 1'b0;
            d1_hs     <= 1'b1;
            d1_vs     <= 1'b1;
            d2_col    <= 3'b000;
            d2_hs     <= 1'b1;
            d2_vs     <= 1'b1;
            O_HSYNC   <= 1'b1;
            O_VSYNC   <= 1'b1;
            O_VIDEO_R <= 4'h0;
            O_VIDEO_G <= 4'h0;
            O_VIDEO_B <= 4'h0;
        end else begin
            d1_act    <= active;
            d1_hs     <= hs_n;
            d1_vs     <= vs_n;
            d2_col    <= d1_act ? rd_dat : 3'b000;
            d2_hs     <= d1_hs;
            d2_vs     <= d1_vs;
            O_HSYNC   <= d2_hs;
            O_VSYNC   <= d2_vs;
            O_VIDEO_R <= {4{d2_col[2]}};
            O_VIDEO_G <= {4{d2_col[1]}};
            O_VIDEO_B <= {4{d2_col[0]}};
        end
    end
endmodule
